// File: rtl/fetch_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
package fetch_pkg;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_INC      = 4;
  localparam int DEF_RESET_PC = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_WAIT = S_WAIT,
    ST_DROP = S_DROP
  } fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// Memory request/response, instruction stream and branch redirect signals of the fetch unit.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    input  branch_valid, branch_target, mem_ready, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output branch_valid, branch_target, mem_ready, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; head is read combinationally so a pushed entry shows one cycle later.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign occupancy = cnt_q;
  assign rdata     = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !clear) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher with one outstanding memory request, branch redirect and prefetch buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                INC      = DEF_INC,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_if.master                bus,
  output logic [$clog2(DEPTH):0] occupancy
);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              push, pop, clear;
  logic              fifo_full, fifo_empty;
  logic [DATA_W+ADDR_W-1:0] head;

  assign bus.mem_req     = (state_q == S_REQ);
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr_data  = head[DATA_W+ADDR_W-1:ADDR_W];
  assign bus.instr_pc    = head[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    clear      = bus.branch_valid;
    pop        = !fifo_empty && bus.instr_ready && !bus.branch_valid;
    if (bus.branch_valid) fetch_pc_d = bus.branch_target;
    case (state_q)
      S_IDLE: if (!fifo_full) state_d = S_REQ;
      S_REQ: if (bus.mem_ready) state_d = bus.branch_valid ? S_DROP : S_WAIT;
      S_WAIT: begin
        // A redirect while waiting turns the in-flight response into garbage.
        if (bus.branch_valid) begin
          state_d = bus.mem_rvalid ? S_IDLE : S_DROP;
        end else if (bus.mem_rvalid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(INC);
          state_d    = S_IDLE;
        end
      end
      S_DROP: if (bus.mem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH(DATA_W + ADDR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .wdata    ({bus.mem_rdata, fetch_pc_q}),
    .rdata    (head),
    .occupancy(occupancy),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized run against a transaction-level queue model of the fetch unit.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [2:0] occupancy;
  int         total = 0;
  int         bad   = 0;

  fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .INC(4), .RESET_PC(32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    bus.instr_ready   = 1'b0;
  endtask

  // Leaves the DUT in its first request cycle (mem_req=1, mem_addr=0).
  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One complete fetch from the request cycle: accept, respond next cycle, back to request.
  task automatic fetch_one(input logic [31:0] data);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", bus.instr_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    reset = 1'b0;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_idle_cycle got=%b exp=0", bus.mem_req); end
    tick();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_first_req got=%b/%h exp=1/00000000", bus.mem_req, bus.mem_addr); end
    $display("test_reset done");
  endtask

  task automatic test_first_fetch;
    do_reset();
    bus.mem_ready = 1'b1;
    tick();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL first_wait_req got=%b exp=0", bus.mem_req); end
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hE3A00001;
    tick();
    bus.mem_rvalid = 1'b0;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_data !== 32'hE3A00001 || bus.instr_pc !== 32'h0) begin
      bad++; $display("FAIL first_head got=%b/%h/%h exp=1/e3a00001/00000000", bus.instr_valid, bus.instr_data, bus.instr_pc); end
    tick();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin bad++; $display("FAIL first_next_req got=%b/%h exp=1/00000004", bus.mem_req, bus.mem_addr); end
    $display("test_first_fetch done");
  endtask

  task automatic test_full;
    do_reset();
    for (int i = 0; i < DEPTH; i++) fetch_one(32'hA000_0000 + i);
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occupancy got=%0d exp=4", occupancy); end
    tick();
    tick();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL full_no_req got=%b exp=0", bus.mem_req); end
    total++; if (bus.instr_data !== 32'hA000_0000 || bus.instr_pc !== 32'h0) begin bad++; $display("FAIL full_head got=%h/%h exp=a0000000/00000000", bus.instr_data, bus.instr_pc); end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    tick();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin bad++; $display("FAIL full_refill_req got=%b/%h exp=1/00000010", bus.mem_req, bus.mem_addr); end
    $display("test_full done");
  endtask

  task automatic test_branch_wait;
    do_reset();
    fetch_one(32'h1111_1111);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready     = 1'b0;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h100;
    tick();
    bus.branch_valid = 1'b0;
    bus.mem_rvalid   = 1'b1;
    bus.mem_rdata    = 32'hDEAD_BEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    total++; if (occupancy !== 3'd0 || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL bwait_dropped got=%0d/%b exp=0/0", occupancy, bus.instr_valid); end
    tick();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin bad++; $display("FAIL bwait_req got=%b/%h exp=1/00000100", bus.mem_req, bus.mem_addr); end
    $display("test_branch_wait done");
  endtask

  task automatic test_branch_req;
    do_reset();
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h200;
    tick();
    bus.branch_valid = 1'b0;
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin bad++; $display("FAIL breq_retarget got=%b/%h exp=1/00000200", bus.mem_req, bus.mem_addr); end
    $display("test_branch_req done");
  endtask

  task automatic test_wrap;
    do_reset();
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    bus.branch_valid = 1'b0;
    fetch_one(32'h5555_AAAA);
    total++; if (bus.instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_head_pc got=%h exp=fffffffc", bus.instr_pc); end
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr got=%b/%h exp=1/00000000", bus.mem_req, bus.mem_addr); end
    $display("test_wrap done");
  endtask

  task automatic test_push_pop;
    do_reset();
    fetch_one(32'hAAAA_0000);
    fetch_one(32'hBBBB_0000);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready   = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_rdata   = 32'hCCCC_0000;
    bus.instr_ready = 1'b1;
    tick();
    bus.mem_rvalid  = 1'b0;
    bus.instr_ready = 1'b0;
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL pp_occupancy got=%0d exp=2", occupancy); end
    total++; if (bus.instr_data !== 32'hBBBB_0000 || bus.instr_pc !== 32'h4) begin bad++; $display("FAIL pp_head1 got=%h/%h exp=bbbb0000/00000004", bus.instr_data, bus.instr_pc); end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    total++; if (bus.instr_data !== 32'hCCCC_0000 || bus.instr_pc !== 32'h8) begin bad++; $display("FAIL pp_head2 got=%h/%h exp=cccc0000/00000008", bus.instr_data, bus.instr_pc); end
    $display("test_push_pop done");
  endtask

  task automatic test_reset_in_wait;
    do_reset();
    fetch_one(32'h7777_7777);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    total++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL rwait_outputs got=%b/%b/%0d exp=0/0/0", bus.mem_req, bus.instr_valid, occupancy); end
    reset          = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h9999_9999;
    tick();
    bus.mem_rvalid = 1'b0;
    total++; if (occupancy !== 3'd0 || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rwait_late_rvalid got=%0d/%b exp=0/0", occupancy, bus.instr_valid); end
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rwait_req got=%b/%h exp=1/00000000", bus.mem_req, bus.mem_addr); end
    $display("test_reset_in_wait done");
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  // Model: the buffer is a queue of fetched words; an outstanding request is tracked
  // together with whether a redirect has orphaned it.
  task automatic test_random;
    ent_t        q[$];
    logic [31:0] model_pc = 32'h0;
    bit          outstanding = 0;
    bit          dropped = 0;
    int          delay = 0;
    bit          hold_req = 0;
    logic [31:0] held_addr = '0;
    int          pushes = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      total++; if (occupancy !== 3'(q.size())) begin bad++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp=%0d", cyc, occupancy, q.size()); end
      total++; if (bus.instr_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.instr_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (bus.instr_data !== q[0].data || bus.instr_pc !== q[0].pc) begin
          bad++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.instr_data, bus.instr_pc, q[0].data, q[0].pc); end
      end
      if (bus.mem_req) begin
        total++; if (q.size() == DEPTH || outstanding) begin bad++; $display("FAIL rnd_illegal_req cyc=%0d got=1 exp=0", cyc); end
      end
      if (hold_req) begin
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== held_addr) begin
          bad++; $display("FAIL rnd_req_stable cyc=%0d got=%b/%h exp=1/%h", cyc, bus.mem_req, bus.mem_addr, held_addr); end
      end

      bus.mem_ready     = ($urandom % 2) == 0;
      bus.instr_ready   = ($urandom % 3) != 0;
      bus.branch_valid  = ($urandom % 16) == 0;
      bus.branch_target = $urandom & 32'hFFFF_FFFC;
      bus.mem_rdata     = $urandom;
      if (outstanding) begin
        bus.mem_rvalid = (delay == 0);
        if (delay > 0) delay--;
      end else begin
        bus.mem_rvalid = ($urandom % 8) == 0;
      end

      hold_req  = bus.mem_req && !bus.mem_ready && !bus.branch_valid;
      held_addr = bus.mem_addr;
      if (bus.mem_req && bus.mem_ready) begin
        total++; if (bus.mem_addr !== model_pc) begin bad++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, model_pc); end
      end

      if (bus.branch_valid) begin
        q.delete();
        if (outstanding && bus.mem_rvalid) outstanding = 0;
        if (outstanding) dropped = 1;
        if (bus.mem_req && bus.mem_ready) begin
          outstanding = 1;
          dropped     = 1;
          delay       = $urandom % 4;
        end
        model_pc = bus.branch_target;
      end else begin
        if (q.size() != 0 && bus.instr_ready) void'(q.pop_front());
        if (outstanding && bus.mem_rvalid) begin
          if (!dropped) begin
            q.push_back('{data: bus.mem_rdata, pc: model_pc});
            model_pc = model_pc + 32'd4;
            pushes++;
          end
          outstanding = 0;
        end else if (bus.mem_req && bus.mem_ready) begin
          outstanding = 1;
          dropped     = 0;
          delay       = $urandom % 4;
        end
      end
      tick();
    end
    idle_inputs();
    total++; if (pushes < 20) begin bad++; $display("FAIL rnd_progress got=%0d exp=>=20", pushes); end
    $display("test_random done pushes=%0d", pushes);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_full();
    test_branch_wait();
    test_branch_req();
    test_wrap();
    test_push_pop();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
